mult_sequencer: RTL



---
 rtl/mult_seq_pkg.sv | 16 +
 rtl/mult_sequencer_bit16_adder.sv | 25 ++
 rtl/mult_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   state_e : FSM state encoding (IDLE / RUN / DONE)
//   PROD_W  : product / datapath width
//   MAX_N   : largest supported operand width
package mult_seq_pkg;

   localparam int PROD_W = 16;
   localparam int MAX_N  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_sequencer_bit16_adder.sv
// 16-bit ripple-carry adder shared by the multiplier sequencer.
// Ports:
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : 16-bit sum (carry out is not brought out; the sequencer
//              never produces a sum wider than 16 bits)
module bit16_Adder (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o
);

   logic carry;

   always_comb begin
      sum_o = '0;
      carry = cin_i;
      for (int i = 0; i < 16; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier controller (unsigned N x N -> 16 bits).
// One partial product per cycle through a shared 16-bit ripple adder.
// Optional feature macro: MULT_SEQ_EARLY_TERM_EN (finish RUN as soon as the
// remaining multiplier bits are all zero).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : request a multiply, captures a and b
//   a, b       : multiplicand / multiplier (N bits)
//   busy       : high while in RUN
//   done       : one-cycle pulse when product updates
//   product    : last completed result, held between operations
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift/add step per clock
// DONE  | product just updated; start here chains the next multiply
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N-1:0]      a,
   input  logic [N-1:0]      b,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   generate
      if (N < 1 || N > MAX_N) begin : g_bad_n
         $error("mult_sequencer: N must be in 1..8");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [N-1:0]        mplier_q, mplier_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PROD_W-1:0]   product_q, product_d;

   logic [PROD_W-1:0]   add_sum;
   logic [PROD_W-1:0]   acc_step;
   logic [N-1:0]        mplier_shift;
   logic                last_step;

   bit16_Adder u_adder (
      .a_i   (acc_q),
      .b_i   (mcand_q),
      .cin_i (1'b0),
      .sum_o (add_sum)
   );

   assign acc_step     = mplier_q[0] ? add_sum : acc_q;
   assign mplier_shift = mplier_q >> 1;

`ifdef MULT_SEQ_EARLY_TERM_EN
   // No remaining set bits means no further adds can change acc.
   assign last_step = (cnt_q == CNT_LAST) || (mplier_shift == '0);
`else
   assign last_step = (cnt_q == CNT_LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d  = PROD_W'(a);
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_step) begin
               product_d = acc_step;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule
